// File: rtl/usb_consts_pkg.sv
// Shared USB constants and types for the IN endpoint scheduler.
package usb_consts_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } sched_state_e;

    localparam int RollbackCntW = 8;

endpackage

// File: rtl/usb_in_ep_slot.sv
// One IN endpoint's queued packet descriptor (pend/buf/size) and its stall flag.
module usb_in_ep_slot
    import usb_consts_pkg::*;
#(
    parameter int BufW  = 5,
    parameter int SizeW = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             link_reset_i,
    input  logic             wr_i,
    input  logic             cancel_i,
    input  logic [BufW-1:0]  buf_i,
    input  logic [SizeW-1:0] size_i,
    input  logic             ack_clr_i,
    input  logic             stall_set_i,
    input  logic             stall_clr_i,
    output logic             pend_o,
    output logic [BufW-1:0]  buf_o,
    output logic [SizeW-1:0] size_o,
    output logic             stall_o
);

    logic             pend_q, pend_d;
    logic [BufW-1:0]  buf_q, buf_d;
    logic [SizeW-1:0] size_q, size_d;
    logic             stall_q, stall_d;

    always_comb begin
        pend_d  = pend_q;
        buf_d   = buf_q;
        size_d  = size_q;
        // Clear beats set; a bus reset leaves stall untouched.
        stall_d = (stall_q | stall_set_i) & ~stall_clr_i;
        if (link_reset_i) begin
            pend_d = 1'b0;
        end else if (wr_i) begin
            pend_d = ~cancel_i;
            if (!cancel_i) begin
                buf_d  = buf_i;
                size_d = size_i;
            end
        end else if (ack_clr_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q  <= 1'b0;
            buf_q   <= '0;
            size_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            buf_q   <= buf_d;
            size_q  <= size_d;
            stall_q <= stall_d;
        end
    end

    assign pend_o  = pend_q;
    assign buf_o   = buf_q;
    assign size_o  = size_q;
    assign stall_o = stall_q;

endmodule

// File: rtl/usb_fs_nb_in_ep_sched.sv
// Per-endpoint IN packet scheduler for the non-buffered IN protocol engine.
// Optional USB_IN_SCHED_ROLLBACK_CNT_EN adds a saturating rollback counter port.
module usb_fs_nb_in_ep_sched
    import usb_consts_pkg::*;
#(
    parameter int NumInEps         = 12,
    parameter int MaxInPktSizeByte = 32,
    parameter int NumBufs          = 32,
    parameter int PktW             = $clog2(MaxInPktSizeByte),
    parameter int InEpW            = $clog2(NumInEps),
    parameter int BufW             = $clog2(NumBufs),
    parameter int SizeW            = PktW + 1,
    parameter int RamAw            = BufW + PktW
) (
    input  logic                clk_48mhz_i,
    input  logic                rst_i,
    input  logic                link_reset_i,
    input  logic                cfg_we_i,
    input  logic [3:0]          cfg_ep_i,
    input  logic [BufW-1:0]     cfg_buf_i,
    input  logic [SizeW-1:0]    cfg_size_i,
    input  logic                cfg_cancel_i,
    output logic                cfg_err_o,
    input  logic [NumInEps-1:0] stall_set_i,
    input  logic [NumInEps-1:0] stall_clr_i,
    input  logic [3:0]          in_ep_current_i,
    input  logic                in_ep_newpkt_i,
    input  logic [PktW-1:0]     in_ep_get_addr_i,
    input  logic                in_ep_data_get_i,
    input  logic                in_ep_acked_i,
    input  logic                in_ep_rollback_i,
    output logic [NumInEps-1:0] in_ep_stall_o,
    output logic [NumInEps-1:0] in_ep_has_data_o,
    output logic [NumInEps-1:0] in_ep_data_done_o,
    output logic [7:0]          in_ep_data_o,
    output logic [RamAw-1:0]    ram_raddr_o,
    input  logic [7:0]          ram_rdata_i,
`ifdef USB_IN_SCHED_ROLLBACK_CNT_EN
    output logic [RollbackCntW-1:0] rollback_cnt_o,
`endif
    output logic                sent_o,
    output logic [3:0]          sent_ep_o,
    output logic [BufW-1:0]     sent_buf_o
);

    sched_state_e     state_q, state_d;
    logic [InEpW-1:0] ep_q, ep_d;
    logic             sent_q, sent_d;
    logic [3:0]       sent_ep_q, sent_ep_d;
    logic [BufW-1:0]  sent_buf_q, sent_buf_d;
    logic             cfg_err_q, cfg_err_d;

    logic [NumInEps-1:0] slot_wr, slot_ack, pend_v, stall_v;
    logic [BufW-1:0]     buf_v  [NumInEps];
    logic [SizeW-1:0]    size_v [NumInEps];
    logic [BufW-1:0]     cur_buf, ep_buf;
    logic                busy, cfg_hit_busy, cfg_size_bad, cfg_ok, ack_fire;

    // The data_get strobe is only observed; the RAM read follows get_addr alone.
    logic unused_data_get;
    assign unused_data_get = in_ep_data_get_i;

    always_comb begin
        cur_buf = '0;
        ep_buf  = '0;
        for (int i = 0; i < NumInEps; i++) begin
            if (in_ep_current_i == 4'(i)) cur_buf = buf_v[i];
            if (ep_q == InEpW'(i))        ep_buf  = buf_v[i];
        end
    end

    assign ram_raddr_o  = {cur_buf, in_ep_get_addr_i};
    assign in_ep_data_o = ram_rdata_i;

    // size == MaxInPktSizeByte never completes; the engine stops at get_addr all-ones.
    always_comb begin
        in_ep_data_done_o = '0;
        for (int i = 0; i < NumInEps; i++) begin
            in_ep_data_done_o[i] = (in_ep_current_i == 4'(i)) &&
                                   ({1'b0, in_ep_get_addr_i} >= size_v[i]);
        end
    end

    always_comb begin
        busy         = (state_q == StBusy);
        cfg_hit_busy = busy && (cfg_ep_i == 4'(ep_q));
        cfg_size_bad = !cfg_cancel_i && (cfg_size_i > SizeW'(MaxInPktSizeByte));
        cfg_ok       = cfg_we_i && !link_reset_i && (cfg_ep_i < 4'(NumInEps)) &&
                       !cfg_hit_busy && !cfg_size_bad;
        cfg_err_d    = cfg_we_i && !link_reset_i && !cfg_ok;
        ack_fire     = busy && in_ep_acked_i && !link_reset_i;
        slot_wr      = '0;
        slot_ack     = '0;
        for (int i = 0; i < NumInEps; i++) begin
            slot_wr[i]  = cfg_ok && (cfg_ep_i == 4'(i));
            slot_ack[i] = ack_fire && (ep_q == InEpW'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        ep_d       = ep_q;
        sent_d     = 1'b0;
        sent_ep_d  = sent_ep_q;
        sent_buf_d = sent_buf_q;
        if (link_reset_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_ep_newpkt_i) begin
                        state_d = StBusy;
                        ep_d    = in_ep_current_i[InEpW-1:0];
                    end
                end
                StBusy: begin
                    if (in_ep_acked_i) begin
                        state_d    = StIdle;
                        sent_d     = 1'b1;
                        sent_ep_d  = 4'(ep_q);
                        sent_buf_d = ep_buf;
                    end else if (in_ep_rollback_i) begin
                        state_d = StIdle;
                    end else if (in_ep_newpkt_i) begin
                        ep_d = in_ep_current_i[InEpW-1:0];
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_48mhz_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            ep_q       <= '0;
            sent_q     <= 1'b0;
            sent_ep_q  <= '0;
            sent_buf_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ep_q       <= ep_d;
            sent_q     <= sent_d;
            sent_ep_q  <= sent_ep_d;
            sent_buf_q <= sent_buf_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    for (genvar g = 0; g < NumInEps; g++) begin : g_slot
        usb_in_ep_slot #(
            .BufW  (BufW),
            .SizeW (SizeW)
        ) u_slot (
            .clk_i        (clk_48mhz_i),
            .rst_i        (rst_i),
            .link_reset_i (link_reset_i),
            .wr_i         (slot_wr[g]),
            .cancel_i     (cfg_cancel_i),
            .buf_i        (cfg_buf_i),
            .size_i       (cfg_size_i),
            .ack_clr_i    (slot_ack[g]),
            .stall_set_i  (stall_set_i[g]),
            .stall_clr_i  (stall_clr_i[g]),
            .pend_o       (pend_v[g]),
            .buf_o        (buf_v[g]),
            .size_o       (size_v[g]),
            .stall_o      (stall_v[g])
        );
    end

`ifdef USB_IN_SCHED_ROLLBACK_CNT_EN
    logic [RollbackCntW-1:0] rb_cnt_q, rb_cnt_d;

    always_comb begin
        rb_cnt_d = rb_cnt_q;
        if (link_reset_i) begin
            rb_cnt_d = '0;
        end else if (in_ep_rollback_i && (rb_cnt_q != '1)) begin
            rb_cnt_d = rb_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_48mhz_i) begin
        if (rst_i) rb_cnt_q <= '0;
        else       rb_cnt_q <= rb_cnt_d;
    end

    assign rollback_cnt_o = rb_cnt_q;
`endif

    assign in_ep_has_data_o = pend_v;
    assign in_ep_stall_o    = stall_v;
    assign sent_o           = sent_q;
    assign sent_ep_o        = sent_ep_q;
    assign sent_buf_o       = sent_buf_q;
    assign cfg_err_o        = cfg_err_q;

endmodule

// File: tb/tb_usb_fs_nb_in_ep_sched.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-level model.
module tb_usb_fs_nb_in_ep_sched;

    localparam int NEP  = 12;
    localparam int MAXP = 32;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, link_reset_i, cfg_we_i, cfg_cancel_i;
    logic [3:0]  cfg_ep_i;
    logic [4:0]  cfg_buf_i;
    logic [5:0]  cfg_size_i;
    logic        cfg_err_o;
    logic [11:0] stall_set_i, stall_clr_i;
    logic [3:0]  in_ep_current_i;
    logic        in_ep_newpkt_i, in_ep_data_get_i, in_ep_acked_i, in_ep_rollback_i;
    logic [4:0]  in_ep_get_addr_i;
    logic [11:0] in_ep_stall_o, in_ep_has_data_o, in_ep_data_done_o;
    logic [7:0]  in_ep_data_o;
    logic [9:0]  ram_raddr_o;
    logic [7:0]  ram_rdata_i;
    logic        sent_o;
    logic [3:0]  sent_ep_o;
    logic [4:0]  sent_buf_o;
`ifdef USB_IN_SCHED_ROLLBACK_CNT_EN
    logic [7:0]  rollback_cnt_o;
`endif

    usb_fs_nb_in_ep_sched dut (
        .clk_48mhz_i       (clk),
        .rst_i             (rst_i),
        .link_reset_i      (link_reset_i),
        .cfg_we_i          (cfg_we_i),
        .cfg_ep_i          (cfg_ep_i),
        .cfg_buf_i         (cfg_buf_i),
        .cfg_size_i        (cfg_size_i),
        .cfg_cancel_i      (cfg_cancel_i),
        .cfg_err_o         (cfg_err_o),
        .stall_set_i       (stall_set_i),
        .stall_clr_i       (stall_clr_i),
        .in_ep_current_i   (in_ep_current_i),
        .in_ep_newpkt_i    (in_ep_newpkt_i),
        .in_ep_get_addr_i  (in_ep_get_addr_i),
        .in_ep_data_get_i  (in_ep_data_get_i),
        .in_ep_acked_i     (in_ep_acked_i),
        .in_ep_rollback_i  (in_ep_rollback_i),
        .in_ep_stall_o     (in_ep_stall_o),
        .in_ep_has_data_o  (in_ep_has_data_o),
        .in_ep_data_done_o (in_ep_data_done_o),
        .in_ep_data_o      (in_ep_data_o),
        .ram_raddr_o       (ram_raddr_o),
        .ram_rdata_i       (ram_rdata_i),
`ifdef USB_IN_SCHED_ROLLBACK_CNT_EN
        .rollback_cnt_o    (rollback_cnt_o),
`endif
        .sent_o            (sent_o),
        .sent_ep_o         (sent_ep_o),
        .sent_buf_o        (sent_buf_o)
    );

    function automatic logic [7:0] ram_f(input logic [9:0] a);
        return a[7:0] ^ {a[9:8], 6'h15};
    endfunction

    always @(posedge clk) ram_rdata_i <= ram_f(ram_raddr_o);

    int checks = 0;
    int failures = 0;

    // Reference model: one queued descriptor per endpoint and the transaction in flight.
    bit m_pend [NEP];
    int m_buf  [NEP];
    int m_size [NEP];
    bit m_stall[NEP];
    bit m_busy;
    int m_ep;
    bit e_sent, e_err;
    int e_sent_ep, e_sent_buf, e_rb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        link_reset_i = 0; cfg_we_i = 0; cfg_cancel_i = 0;
        in_ep_newpkt_i = 0; in_ep_acked_i = 0; in_ep_rollback_i = 0;
        stall_set_i = '0; stall_clr_i = '0; in_ep_data_get_i = 0;
    endtask

    task automatic model_update();
        bit o_busy;
        int o_ep, ce;
        o_busy = m_busy;
        o_ep   = m_ep;
        e_sent = 0;
        e_err  = 0;
        if (rst_i) begin
            foreach (m_pend[i]) begin
                m_pend[i] = 0; m_buf[i] = 0; m_size[i] = 0; m_stall[i] = 0;
            end
            m_busy = 0; m_ep = 0; e_rb = 0;
            return;
        end
        foreach (m_stall[i]) m_stall[i] = (m_stall[i] | stall_set_i[i]) & ~stall_clr_i[i];
        if (link_reset_i) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_busy = 0;
            e_rb   = 0;
            return;
        end
        if (in_ep_rollback_i && e_rb < 255) e_rb++;
        if (o_busy && in_ep_acked_i) begin
            e_sent = 1; e_sent_ep = o_ep; e_sent_buf = m_buf[o_ep];
            m_pend[o_ep] = 0;
            m_busy = 0;
        end else if (o_busy && in_ep_rollback_i) begin
            m_busy = 0;
        end else if (in_ep_newpkt_i) begin
            m_busy = 1;
            m_ep   = int'(in_ep_current_i);
        end
        if (cfg_we_i) begin
            ce = int'(cfg_ep_i);
            if (ce >= NEP || (o_busy && ce == o_ep) || (!cfg_cancel_i && int'(cfg_size_i) > MAXP))
                e_err = 1;
            else if (cfg_cancel_i)
                m_pend[ce] = 0;
            else begin
                m_pend[ce] = 1; m_buf[ce] = int'(cfg_buf_i); m_size[ce] = int'(cfg_size_i);
            end
        end
    endtask

    // One clock: check combinational outputs, advance model, check registered outputs.
    task automatic step();
        logic [11:0] exp_done, exp_pend, exp_stall;
        logic [9:0]  exp_raddr;
        int cur;
        #1;
        cur = int'(in_ep_current_i);
        exp_done = '0;
        if (cur < NEP && int'(in_ep_get_addr_i) >= m_size[cur]) exp_done[cur] = 1'b1;
        exp_raddr = 10'((cur < NEP ? m_buf[cur] : 0) * MAXP + int'(in_ep_get_addr_i));
        if (!rst_i) begin
            chk("data_done", in_ep_data_done_o, exp_done);
            chk("ram_raddr", ram_raddr_o, exp_raddr);
        end
        model_update();
        @(posedge clk);
        #1;
        foreach (m_pend[i]) begin
            exp_pend[i]  = m_pend[i];
            exp_stall[i] = m_stall[i];
        end
        chk("has_data", in_ep_has_data_o, exp_pend);
        chk("stall", in_ep_stall_o, exp_stall);
        chk("sent", sent_o, e_sent);
        chk("cfg_err", cfg_err_o, e_err);
        if (e_sent) begin
            chk("sent_ep", sent_ep_o, e_sent_ep);
            chk("sent_buf", sent_buf_o, e_sent_buf);
        end
        if (!rst_i) chk("data_out", in_ep_data_o, ram_f(exp_raddr));
`ifdef USB_IN_SCHED_ROLLBACK_CNT_EN
        chk("rb_cnt", rollback_cnt_o, e_rb);
`endif
        clear_inputs();
    endtask

    task automatic queue(input int ep, input int b, input int sz);
        cfg_we_i = 1; cfg_ep_i = 4'(ep); cfg_buf_i = 5'(b); cfg_size_i = 6'(sz); cfg_cancel_i = 0;
        step();
    endtask

    task automatic newpkt(input int ep);
        in_ep_current_i = 4'(ep); in_ep_newpkt_i = 1; in_ep_get_addr_i = 0;
        step();
    endtask

    initial begin
        clear_inputs();
        rst_i = 1; cfg_ep_i = 0; cfg_buf_i = 0; cfg_size_i = 0;
        in_ep_current_i = 0; in_ep_get_addr_i = 0;
        step();
        step();
        chk("rst_has_data", in_ep_has_data_o, 0);
        chk("rst_sent", sent_o, 0);
        rst_i = 0;
        step();

        // Three-byte packet on ep2 from buffer 5.
        queue(2, 5, 3);
        newpkt(2);
        for (int a = 0; a < 4; a++) begin
            in_ep_get_addr_i = 5'(a);
            #1;
            chk("tp1_raddr", ram_raddr_o, 5 * 32 + a);
            chk("tp1_done", in_ep_data_done_o[2], (a == 3) ? 1 : 0);
            chk("tp1_has_data", in_ep_has_data_o[2], 1);
            step();
        end
        in_ep_acked_i = 1;
        step();
        chk("tp1_sent", {sent_o, sent_ep_o, sent_buf_o}, {1'b1, 4'd2, 5'd5});
        chk("tp1_cleared", in_ep_has_data_o[2], 0);

        // Zero-length packet on ep1.
        queue(1, 3, 0);
        newpkt(1);
        #1;
        chk("zlp_done", in_ep_data_done_o[1], 1);
        in_ep_acked_i = 1;
        step();
        chk("zlp_sent_ep", sent_ep_o, 1);

        // Rollback keeps ep3 queued and the retry rereads from offset 0.
        queue(3, 9, 4);
        newpkt(3);
        for (int a = 0; a < 3; a++) begin
            in_ep_get_addr_i = 5'(a);
            step();
        end
        in_ep_rollback_i = 1;
        step();
        chk("rb_pend", in_ep_has_data_o[3], 1);
        chk("rb_nosent", sent_o, 0);
        newpkt(3);
        #1;
        chk("rb_retry_raddr", ram_raddr_o, 9 * 32);
        in_ep_acked_i = 1;
        step();

        // Write to the busy endpoint is refused; another endpoint is fine.
        queue(4, 7, 2);
        newpkt(4);
        queue(4, 11, 1);
        chk("busy_err", cfg_err_o, 1);
        queue(5, 12, 1);
        chk("busy_err_pulse", cfg_err_o, 0);
        chk("ep5_pend", in_ep_has_data_o[5], 1);
        in_ep_acked_i = 1;
        step();
        chk("busy_buf_kept", sent_buf_o, 7);

        // Stall set/clear.
        stall_set_i[6] = 1; stall_clr_i[6] = 1;
        step();
        chk("stall_clr_wins", in_ep_stall_o[6], 0);
        stall_set_i[6] = 1;
        step();
        chk("stall_set", in_ep_stall_o[6], 1);

        // Bus reset mid-transfer.
        queue(0, 1, 8);
        queue(7, 2, 8);
        newpkt(0);
        in_ep_get_addr_i = 1;
        step();
        link_reset_i = 1;
        step();
        chk("lr_has_data", in_ep_has_data_o, 0);
        chk("lr_stall_kept", in_ep_stall_o[6], 1);
        in_ep_acked_i = 1;
        step();
        chk("lr_idle_nosent", sent_o, 0);

        // Oversize and out-of-range writes.
        queue(8, 4, 33);
        chk("oversize_err", cfg_err_o, 1);
        queue(13, 4, 2);
        chk("range_err", cfg_err_o, 1);
        queue(9, 4, 32);
        chk("maxsize_ok", cfg_err_o, 0);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            in_ep_current_i  = 4'($urandom_range(0, NEP - 1));
            in_ep_get_addr_i = 5'($urandom_range(0, 31));
            in_ep_newpkt_i   = ($urandom_range(0, 99) < 20);
            in_ep_acked_i    = ($urandom_range(0, 99) < 10);
            in_ep_rollback_i = ($urandom_range(0, 99) < 8);
            in_ep_data_get_i = 1'($urandom_range(0, 1));
            cfg_we_i         = ($urandom_range(0, 99) < 30);
            cfg_cancel_i     = ($urandom_range(0, 99) < 20);
            cfg_ep_i         = 4'($urandom_range(0, 13));
            cfg_buf_i        = 5'($urandom_range(0, 31));
            cfg_size_i       = 6'($urandom_range(0, 34));
            link_reset_i     = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 10) stall_set_i[$urandom_range(0, NEP - 1)] = 1'b1;
            if ($urandom_range(0, 99) < 10) stall_clr_i[$urandom_range(0, NEP - 1)] = 1'b1;
            step();
        end

`ifdef USB_IN_SCHED_ROLLBACK_CNT_EN
        link_reset_i = 1;
        step();
        for (int n = 0; n < 300; n++) begin
            in_ep_rollback_i = 1;
            step();
        end
        chk("rb_cnt_sat", rollback_cnt_o, 255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
